// File: rtl/crtg_hw_controller.sv
// crtg_hw_controller: compaction random test generation with fault dropping.
// An LFSR proposes vectors; each still-undetected fault is injected in turn via
// a 4-phase handshake, good/faulty outputs are compared after a settle delay,
// and a vector is kept only if it detects at least EF_COUNT new faults.
//
// Handshake (4-phase): inj_req rises with inj_idx stable; harness raises
// inj_ack once the fault is in place; inj_req falls after the compare; harness
// drops inj_ack; only then may a new request start.
module crtg_hw_controller #(
  parameter int VEC_W      = 157,
  parameter int OUT_W      = 64,
  parameter int NUM_FAULTS = 1798,
  parameter int FIDX_W     = 11,
  parameter int EF_COUNT   = 1,
  parameter int UT_LIMIT   = 300,
  parameter int COV_PCT    = 95,
  parameter int SETTLE     = 6,
  // Default puts feedback at the MSB plus a few low taps; override with a
  // primitive polynomial mask for the target width.
  parameter logic [VEC_W-1:0] LFSR_TAPS = {1'b1, {(VEC_W-8){1'b0}}, 7'h47},
  parameter logic [VEC_W-1:0] SEED      = {{(VEC_W-1){1'b0}}, 1'b1}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [VEC_W-1:0]    test_vec,
  output logic                inj_req,
  output logic [FIDX_W-1:0]   inj_idx,
  input  logic                inj_ack,
  input  logic [OUT_W-1:0]    good_out,
  input  logic [OUT_W-1:0]    faulty_out,
  output logic                vec_valid,
  output logic                busy,
  output logic                done,
  output logic                cov_met,
  output logic [FIDX_W:0]     det_total,
  output logic [8:0]          useless_cnt
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [VEC_W-1:0] SEED_EFF =
    (SEED == '0) ? {{(VEC_W-1){1'b0}}, 1'b1} : SEED;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST   = FIDX_W'(NUM_FAULTS - 1);
  localparam logic [FIDX_W:0]   EF_MIN      = (FIDX_W+1)'(EF_COUNT);
  localparam logic [8:0]        UT_MAX      = 9'(UT_LIMIT);
  localparam logic [31:0]       COV_THR     = 32'(COV_PCT * NUM_FAULTS);

  typedef enum logic [3:0] {
    IDLE, GEN, CHK, INJ, SET, CMP, REL, NEXT, COMMIT, EXIT, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [VEC_W-1:0]        lfsr_q, lfsr_d;
  logic [VEC_W-1:0]        test_vec_q, test_vec_d;
  logic                    inj_req_q, inj_req_d;
  logic [FIDX_W-1:0]       inj_idx_q, inj_idx_d;
  logic [FIDX_W-1:0]       fidx_q, fidx_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [NUM_FAULTS-1:0]   at_q, at_d;
  logic [NUM_FAULTS-1:0]   ct_q, ct_d;
  logic [FIDX_W:0]         det_ct_q, det_ct_d;
  logic [FIDX_W:0]         det_total_q, det_total_d;
  logic [8:0]              useless_q, useless_d;
  logic                    vec_valid_q, vec_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cov_met_q, cov_met_d;
  logic [31:0]             det_x100;

  // One Galois step: shift right, fold the feedback mask in when a 1 falls out.
  function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Coverage test without division: det_total*100 vs COV_PCT*NUM_FAULTS.
  assign det_x100 = 32'(det_total_q) * 32'd100;

  // Next-state and next-output logic for the whole run sequence.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    test_vec_d  = test_vec_q;
    inj_req_d   = inj_req_q;
    inj_idx_d   = inj_idx_q;
    fidx_d      = fidx_q;
    settle_d    = settle_q;
    at_d        = at_q;
    ct_d        = ct_q;
    det_ct_d    = det_ct_q;
    det_total_d = det_total_q;
    useless_d   = useless_q;
    vec_valid_d = 1'b0;
    done_d      = done_q;
    cov_met_d   = cov_met_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          det_total_d = '0;
          useless_d   = '0;
          at_d        = '0;
          ct_d        = '0;
          done_d      = 1'b0;
          cov_met_d   = 1'b0;
          lfsr_d      = SEED_EFF;
          state_d     = GEN;
        end
      end
      GEN: begin
        lfsr_d     = lfsr_step(lfsr_q);
        test_vec_d = lfsr_step(lfsr_q);
        ct_d       = '0;
        det_ct_d   = '0;
        fidx_d     = '0;
        state_d    = CHK;
      end
      CHK: begin
        // Already-detected faults are dropped without a handshake.
        if (at_q[fidx_q]) begin
          state_d = NEXT;
        end else begin
          inj_req_d = 1'b1;
          inj_idx_d = fidx_q;
          state_d   = INJ;
        end
      end
      INJ: begin
        if (inj_ack) begin
          settle_d = '0;
          state_d  = SET;
        end
      end
      SET: begin
        if (settle_q == SETTLE_LAST) state_d = CMP;
        else                         settle_d = settle_q + SW'(1);
      end
      CMP: begin
        if (good_out != faulty_out) begin
          ct_d[fidx_q] = 1'b1;
          det_ct_d     = det_ct_q + (FIDX_W+1)'(1);
        end
        inj_req_d = 1'b0;
        state_d   = REL;
      end
      REL: begin
        if (!inj_ack) state_d = NEXT;
      end
      NEXT: begin
        if (fidx_q == FIDX_LAST) begin
          state_d = COMMIT;
        end else begin
          fidx_d  = fidx_q + FIDX_W'(1);
          state_d = CHK;
        end
      end
      COMMIT: begin
        if (det_ct_q >= EF_MIN) begin
          at_d        = at_q | ct_q;
          det_total_d = det_total_q + det_ct_q;
          useless_d   = '0;
          vec_valid_d = 1'b1;
        end else begin
          useless_d   = useless_q + 9'd1;
        end
        state_d = EXIT;
      end
      EXIT: begin
        if (det_x100 >= COV_THR) begin
          cov_met_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (useless_q == UT_MAX) begin
          cov_met_d = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          state_d   = GEN;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = !(state_d inside {IDLE, DONE});
  end

  // State and registered outputs; async reset drops inj_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      test_vec_q  <= '0;
      inj_req_q   <= 1'b0;
      inj_idx_q   <= '0;
      fidx_q      <= '0;
      settle_q    <= '0;
      at_q        <= '0;
      ct_q        <= '0;
      det_ct_q    <= '0;
      det_total_q <= '0;
      useless_q   <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cov_met_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      test_vec_q  <= test_vec_d;
      inj_req_q   <= inj_req_d;
      inj_idx_q   <= inj_idx_d;
      fidx_q      <= fidx_d;
      settle_q    <= settle_d;
      at_q        <= at_d;
      ct_q        <= ct_d;
      det_ct_q    <= det_ct_d;
      det_total_q <= det_total_d;
      useless_q   <= useless_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cov_met_q   <= cov_met_d;
    end
  end

  assign test_vec    = test_vec_q;
  assign inj_req     = inj_req_q;
  assign inj_idx     = inj_idx_q;
  assign vec_valid   = vec_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cov_met     = cov_met_q;
  assign det_total   = det_total_q;
  assign useless_cnt = useless_q;

endmodule

// File: tb/tb_crtg_hw_controller.sv
// Directed bench for crtg_hw_controller with an 8-bit LFSR (taps B8, seed 1,
// sequence B8, 5C, 2E, 17, ...) and four faults. dut_a keeps vectors with one
// new detection; dut_b needs two.
module tb_crtg_hw_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- dut_a: EF_COUNT=1, UT_LIMIT=3 ----------------
  logic       start_a = 1'b0;
  logic [7:0] test_vec_a;
  logic       inj_req_a, inj_ack_a, d1_a;
  logic [1:0] inj_idx_a;
  logic [7:0] good_a, faulty_a;
  logic       vec_valid_a, busy_a, done_a, cov_met_a;
  logic [2:0] det_total_a;
  logic [8:0] useless_a;
  logic       mode_a = 1'b0;   // 0: faults 0,2 always, 1,3 when bit0; 1: never
  logic       stall = 1'b0;    // holds inj_ack_a low

  crtg_hw_controller #(
    .VEC_W(8), .OUT_W(8), .NUM_FAULTS(4), .FIDX_W(2), .EF_COUNT(1),
    .UT_LIMIT(3), .COV_PCT(95), .SETTLE(6), .LFSR_TAPS(8'hB8), .SEED(8'h01)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .test_vec(test_vec_a),
    .inj_req(inj_req_a), .inj_idx(inj_idx_a), .inj_ack(inj_ack_a),
    .good_out(good_a), .faulty_out(faulty_a), .vec_valid(vec_valid_a),
    .busy(busy_a), .done(done_a), .cov_met(cov_met_a),
    .det_total(det_total_a), .useless_cnt(useless_a)
  );

  // Harness a: ack follows req two cycles later on both edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_a      <= 1'b0;
      inj_ack_a <= 1'b0;
    end else begin
      d1_a      <= inj_req_a;
      inj_ack_a <= stall ? 1'b0 : d1_a;
    end
  end
  assign good_a   = 8'h5A;
  assign faulty_a = (!mode_a && (!inj_idx_a[0] || test_vec_a[0])) ? 8'hA5 : 8'h5A;

  // ---------------- dut_b: EF_COUNT=2, UT_LIMIT=3 ----------------
  logic       start_b = 1'b0;
  logic [7:0] test_vec_b;
  logic       inj_req_b, inj_ack_b, d1_b;
  logic [1:0] inj_idx_b;
  logic [7:0] good_b, faulty_b;
  logic       vec_valid_b, busy_b, done_b, cov_met_b;
  logic [2:0] det_total_b;
  logic [8:0] useless_b;

  crtg_hw_controller #(
    .VEC_W(8), .OUT_W(8), .NUM_FAULTS(4), .FIDX_W(2), .EF_COUNT(2),
    .UT_LIMIT(3), .COV_PCT(95), .SETTLE(6), .LFSR_TAPS(8'hB8), .SEED(8'h01)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .test_vec(test_vec_b),
    .inj_req(inj_req_b), .inj_idx(inj_idx_b), .inj_ack(inj_ack_b),
    .good_out(good_b), .faulty_out(faulty_b), .vec_valid(vec_valid_b),
    .busy(busy_b), .done(done_b), .cov_met(cov_met_b),
    .det_total(det_total_b), .useless_cnt(useless_b)
  );

  // Harness b: same timing; only fault 0 is ever detectable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_b      <= 1'b0;
      inj_ack_b <= 1'b0;
    end else begin
      d1_b      <= inj_req_b;
      inj_ack_b <= d1_b;
    end
  end
  assign good_b   = 8'h3C;
  assign faulty_b = (inj_idx_b == 2'd0) ? 8'hC3 : 8'h3C;

  // ---------------- monitors ----------------
  logic [1:0] inj_q[$];
  int         gap_q[$];
  logic [7:0] kept_q[$];
  logic [1:0] inj_b_q[$];
  int         cyc = 0;
  int         fall_cyc = 0;
  int         tv_changes = 0;
  int         vv_b = 0;
  logic       prev_req_a = 1'b0;
  logic       prev_req_b = 1'b0;
  logic [7:0] prev_tv_a = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (inj_req_a && !prev_req_a) begin
      inj_q.push_back(inj_idx_a);
      gap_q.push_back(cyc - fall_cyc);
    end
    if (!inj_req_a && prev_req_a) fall_cyc = cyc;
    if (vec_valid_a) kept_q.push_back(test_vec_a);
    if (test_vec_a != prev_tv_a) tv_changes = tv_changes + 1;
    if (inj_req_b && !prev_req_b) inj_b_q.push_back(inj_idx_b);
    if (vec_valid_b) vv_b = vv_b + 1;
    prev_req_a = inj_req_a;
    prev_req_b = inj_req_b;
    prev_tv_a  = test_vec_a;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tests_run++;
    if ({test_vec_a, inj_req_a, inj_idx_a, vec_valid_a, busy_a, done_a,
         cov_met_a, det_total_a, useless_a} !== 26'd0) begin
      fails++;
      $display("FAIL reset_outputs: got tv=%h req=%b busy=%b done=%b det=%0d want all 0",
               test_vec_a, inj_req_a, busy_a, done_a, det_total_a);
    end
  endtask

  // Coverage run with a start pulse while busy that must be ignored.
  task automatic test_coverage_run();
    logic [1:0] exp_q[$];
    int n;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    mode_a = 1'b0;
    inj_q.delete(); gap_q.delete(); kept_q.delete();
    pulse_start_a();
    repeat (30) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    n = 0;
    while (!done_a && n < 5000) begin @(negedge clk); n++; end
    tests_run++;
    if (done_a !== 1'b1) begin fails++; $display("FAIL cov_done_timeout: done=%b want 1", done_a); end
    tests_run++;
    if (det_total_a !== 3'd4) begin fails++; $display("FAIL cov_det_total: got %0d want 4", det_total_a); end
    tests_run++;
    if (cov_met_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++; $display("FAIL cov_flags: cov_met=%b busy=%b want 1 0", cov_met_a, busy_a);
    end
    tests_run++;
    if (useless_a !== 9'd0) begin fails++; $display("FAIL cov_useless: got %0d want 0", useless_a); end
    tests_run++;
    if (kept_q.size() != 2) begin
      fails++; $display("FAIL cov_kept_count: got %0d want 2", kept_q.size());
    end else if (kept_q[0] !== 8'hB8 || kept_q[1] !== 8'h17 || kept_q[1][0] !== 1'b1) begin
      fails++; $display("FAIL cov_kept_vecs: got %h %h want b8 17", kept_q[0], kept_q[1]);
    end
    // Fault dropping: indices 0 and 2 never reappear once detected.
    tests_run++;
    if (inj_q.size() != exp_q.size()) begin
      fails++; $display("FAIL drop_inj_count: got %0d want %0d", inj_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (inj_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL drop_inj_seq[%0d]: got %0d want %0d", i, inj_q[i], exp_q[i]);
          break;
        end
      end
    end
    // req fall -> REL(3) -> NEXT -> CHK -> INJ: 5 cycles; one skipped fault
    // adds one CHK cycle plus its NEXT cycle: 7.
    tests_run++;
    if (gap_q.size() < 6 || gap_q[1] != 5 || gap_q[5] != 7) begin
      fails++;
      $display("FAIL drop_skip_cycles: got n=%0d gap1=%0d gap5=%0d want 5 7", gap_q.size(),
               (gap_q.size() > 1) ? gap_q[1] : -1, (gap_q.size() > 5) ? gap_q[5] : -1);
    end
  endtask

  // Restart from DONE with a harness that never detects anything.
  task automatic test_restart_useless();
    int n;
    mode_a = 1'b1;
    inj_q.delete(); kept_q.delete();
    tv_changes = 0;
    pulse_start_a();
    tests_run++;
    if (det_total_a !== 3'd0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      fails++; $display("FAIL restart_clear: det=%0d busy=%b done=%b want 0 1 0",
                        det_total_a, busy_a, done_a);
    end
    @(negedge clk);
    tests_run++;
    if (test_vec_a !== 8'hB8) begin fails++; $display("FAIL restart_first_vec: got %h want b8", test_vec_a); end
    n = 0;
    while (!done_a && n < 5000) begin @(negedge clk); n++; end
    tests_run++;
    if (done_a !== 1'b1 || cov_met_a !== 1'b0 || det_total_a !== 3'd0) begin
      fails++; $display("FAIL useless_end: done=%b cov=%b det=%0d want 1 0 0", done_a, cov_met_a, det_total_a);
    end
    tests_run++;
    if (tv_changes != 3 || test_vec_a !== 8'h2E || useless_a !== 9'd3) begin
      fails++; $display("FAIL useless_vec_count: changes=%0d tv=%h useless=%0d want 3 2e 3",
                        tv_changes, test_vec_a, useless_a);
    end
    tests_run++;
    if (kept_q.size() != 0 || inj_q.size() != 12) begin
      fails++; $display("FAIL useless_no_keep: kept=%0d inj=%0d want 0 12", kept_q.size(), inj_q.size());
    end
  endtask

  // EF_COUNT=2 with one detection per vector: nothing commits.
  task automatic test_ef_count();
    int n;
    inj_b_q.delete();
    vv_b = 0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (!done_b && n < 5000) begin @(negedge clk); n++; end
    tests_run++;
    if (done_b !== 1'b1 || cov_met_b !== 1'b0 || det_total_b !== 3'd0 || useless_b !== 9'd3) begin
      fails++; $display("FAIL ef_end: done=%b cov=%b det=%0d useless=%0d want 1 0 0 3",
                        done_b, cov_met_b, det_total_b, useless_b);
    end
    tests_run++;
    if (vv_b != 0) begin fails++; $display("FAIL ef_vec_valid: got %0d pulses want 0", vv_b); end
    // AT stays empty, so every vector injects all four faults again.
    tests_run++;
    if (inj_b_q.size() != 12) begin
      fails++; $display("FAIL ef_at_empty_count: got %0d want 12", inj_b_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (inj_b_q[i] !== 2'(i % 4)) begin
          fails++; $display("FAIL ef_at_empty_seq[%0d]: got %0d want %0d", i, inj_b_q[i], i % 4);
          break;
        end
      end
    end
  endtask

  // Stalled ack keeps inj_req up; async reset mid-INJ clears everything.
  task automatic test_stall_reset();
    int n;
    int low_cnt;
    mode_a = 1'b0;
    stall  = 1'b1;
    pulse_start_a();
    n = 0;
    while (!inj_req_a && n < 100) begin @(negedge clk); n++; end
    tests_run++;
    if (inj_req_a !== 1'b1) begin fails++; $display("FAIL stall_req_rise: got %b want 1", inj_req_a); end
    low_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (inj_req_a !== 1'b1 || vec_valid_a !== 1'b0 || det_total_a !== 3'd0) low_cnt++;
    end
    tests_run++;
    if (low_cnt != 0) begin fails++; $display("FAIL stall_hold: bad cycles %0d want 0", low_cnt); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (inj_req_a !== 1'b0) begin fails++; $display("FAIL async_reset_req: got %b want 0", inj_req_a); end
    tests_run++;
    if ({test_vec_a, inj_idx_a, vec_valid_a, busy_a, done_a, cov_met_a,
         det_total_a, useless_a} !== 25'd0) begin
      fails++; $display("FAIL async_reset_outputs: tv=%h busy=%b done=%b det=%0d want all 0",
                        test_vec_a, busy_a, done_a, det_total_a);
    end
    stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_coverage_run();
    test_restart_useless();
    test_ef_count();
    test_stall_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
